// File: rtl/ft800_pkg.sv
// Shared constants and types for the FT800 bus bridge: SPI opcodes, frame
// lengths, controller states and the byte-order helper.
package ft800_pkg;

  localparam int FRAME_W = 48;
  localparam int CNT_W   = 6;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b10;

  localparam logic [CNT_W-1:0] LEN_READ  = 6'd48;
  localparam logic [CNT_W-1:0] LEN_WRITE = 6'd40;
  localparam logic [CNT_W-1:0] LEN_CMD   = 6'd24;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  function automatic logic [15:0] swap_bytes(input logic [15:0] w);
    return {w[7:0], w[15:8]};
  endfunction

endpackage

// File: rtl/ft800_spi_shift.sv
// Generic MSB-first SPI mode-0 shift engine: frames up to 48 bits, generates
// spi_clk at clk/(2*SCLK_HALF), captures miso on rising edges, pulses done_o.
module ft800_spi_shift
  import ft800_pkg::*;
#(
  parameter int SCLK_HALF = 1,
  parameter int RX_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_i,
  input  logic [FRAME_W-1:0]  frame_i,
  input  logic [CNT_W-1:0]    len_i,
  input  logic                miso_i,
  output logic                mosi_o,
  output logic                sclk_o,
  output logic                active_o,
  output logic                done_o,
  output logic [RX_W-1:0]     rx_o
);

  localparam int DIV_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam logic [DIV_W-1:0] HALF_M1 = DIV_W'(SCLK_HALF - 1);

  logic               active_q;
  logic               sclk_q;
  logic               done_q;
  logic [DIV_W-1:0]   div_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   len_q;
  logic [FRAME_W-1:0] tx_q;
  logic [RX_W-1:0]    rx_q;

  logic start, tick, rise, fall, last;

  assign start = load_i && !active_q;
  assign tick  = active_q && (div_q == HALF_M1);
  assign rise  = tick && !sclk_q;
  assign fall  = tick && sclk_q;
  // The falling half-period after the final rise ends the frame, so select
  // drops SCLK_HALF cycles after the last rising edge with the clock low.
  assign last  = fall && (cnt_q == len_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      sclk_q   <= 1'b0;
      done_q   <= 1'b0;
      div_q    <= '0;
      cnt_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        active_q <= 1'b1;
        sclk_q   <= 1'b0;
        div_q    <= '0;
        cnt_q    <= '0;
      end else if (active_q) begin
        if (tick) begin
          div_q <= '0;
          if (rise) begin
            sclk_q <= 1'b1;
            cnt_q  <= cnt_q + CNT_W'(1);
          end else begin
            sclk_q <= 1'b0;
            if (last) begin
              active_q <= 1'b0;
              done_q   <= 1'b1;
            end
          end
        end else begin
          div_q <= div_q + DIV_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      tx_q  <= frame_i;
      len_q <= len_i;
    end else if (fall && !last) begin
      tx_q <= {tx_q[FRAME_W-2:0], 1'b0};
    end
    if (rise) begin
      rx_q <= {rx_q[RX_W-2:0], miso_i};
    end
  end

  assign mosi_o   = active_q & tx_q[FRAME_W-1];
  assign sclk_o   = sclk_q;
  assign active_o = active_q;
  assign done_o   = done_q;
  assign rx_o     = rx_q;

endmodule

// File: rtl/ft800_bus_bridge.sv
// 68000-style word bus to FT800 SPI bridge: one select-framed SPI transaction
// per bus access. Define FT800_BYTE_SWAP_EN for big-endian data byte order.
module ft800_bus_bridge
  import ft800_pkg::*;
#(
  parameter int SCLK_HALF = 1
) (
  input  logic        rst,
  input  logic        clk,
  input  logic [21:1] addr,
  inout  wire  [15:0] data,
  input  logic        write,
  input  logic        command,
  input  logic        enable,
  output logic        complete,
  output logic        mosi,
  input  logic        miso,
  output logic        chip_select,
  output logic        spi_clk
);

  state_t             state_q;
  logic               is_read_q;
  logic               complete_q;
  logic               drive_q;
  logic [15:0]        rdata_q;

  logic               start;
  logic [FRAME_W-1:0] frame_d;
  logic [CNT_W-1:0]   len_d;
  logic [15:0]        wr_bytes;
  logic [15:0]        rd_word;
  logic [15:0]        rx_w;
  logic               spi_done;

`ifdef FT800_BYTE_SWAP_EN
  assign wr_bytes = data;
  assign rd_word  = rx_w;
`else
  assign wr_bytes = swap_bytes(data);
  assign rd_word  = swap_bytes(rx_w);
`endif

  assign start = (state_q == IDLE) && enable;

  // Frames are MSB-aligned in the 48-bit engine; shorter frames leave zeros below.
  always_comb begin
    frame_d = '0;
    len_d   = LEN_CMD;
    if (command) begin
      frame_d = {addr[8:1], 40'h0};
      len_d   = LEN_CMD;
    end else if (write) begin
      frame_d = {OP_WRITE, 1'b0, addr, wr_bytes, 8'h00};
      len_d   = LEN_WRITE;
    end else begin
      frame_d = {OP_READ, 1'b0, addr, 24'h0};
      len_d   = LEN_READ;
    end
  end

  ft800_spi_shift #(
    .SCLK_HALF (SCLK_HALF),
    .RX_W      (16)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .load_i   (start),
    .frame_i  (frame_d),
    .len_i    (len_d),
    .miso_i   (miso),
    .mosi_o   (mosi),
    .sclk_o   (spi_clk),
    .active_o (chip_select),
    .done_o   (spi_done),
    .rx_o     (rx_w)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      is_read_q  <= 1'b0;
      complete_q <= 1'b0;
      drive_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable) begin
            state_q   <= SHIFT;
            is_read_q <= !command && !write;
          end
        end
        SHIFT: begin
          if (spi_done) begin
            state_q    <= DONE;
            complete_q <= 1'b1;
            drive_q    <= is_read_q;
          end
        end
        DONE: begin
          if (!enable) begin
            state_q    <= IDLE;
            complete_q <= 1'b0;
            drive_q    <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The last 16 received bits are the two data bytes; dummy bits shift out.
  always_ff @(posedge clk) begin
    if ((state_q == SHIFT) && spi_done) begin
      rdata_q <= rd_word;
    end
  end

  assign complete = complete_q;
  assign data     = drive_q ? rdata_q : 16'hzzzz;

endmodule

// File: tb/tb_ft800_bus_bridge.sv
// Bench for ft800_bus_bridge: directed and random accesses against a
// frame-level reference model of the SPI transaction and bus handshake.
module tb_ft800_bus_bridge;

  localparam int H = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [21:1] addr;
  wire  [15:0] data;
  logic        write;
  logic        command;
  logic        enable;
  logic        complete;
  logic        mosi;
  logic        miso;
  logic        chip_select;
  logic        spi_clk;

  logic        tb_oe;
  logic [15:0] tb_dout;

  int total = 0;
  int bad   = 0;

  assign data = tb_oe ? tb_dout : 16'hzzzz;

  always #5 clk = ~clk;

  ft800_bus_bridge #(.SCLK_HALF(H)) dut (
    .rst         (rst),
    .clk         (clk),
    .addr        (addr),
    .data        (data),
    .write       (write),
    .command     (command),
    .enable      (enable),
    .complete    (complete),
    .mosi        (mosi),
    .miso        (miso),
    .chip_select (chip_select),
    .spi_clk     (spi_clk)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // kind: 0 = read, 1 = write, 2 = command. mvec holds the 48 miso bits, MSB first.
  task automatic access(input int kind, input logic [21:1] a, input logic [15:0] wd,
                        input logic [47:0] mvec, input bit drop_early, input string tag);
    logic [47:0] exp_frame;
    logic [47:0] got;
    logic [15:0] exp_rd;
    int          len;
    int          rises;
    int          last_rise;
    int          cs_drop;
    bit          timing_ok;
    bit          done;
    bit          prev_sclk;
    bit          prev_cs;
    logic        prev_mosi;

    if (kind == 0) begin
      len       = 48;
      exp_frame = {2'b00, 1'b0, a, 8'h00, 16'h0000};
    end else if (kind == 1) begin
      len = 40;
`ifdef FT800_BYTE_SWAP_EN
      exp_frame = {8'h00, 2'b10, 1'b0, a, wd[15:8], wd[7:0]};
`else
      exp_frame = {8'h00, 2'b10, 1'b0, a, wd[7:0], wd[15:8]};
`endif
    end else begin
      len       = 24;
      exp_frame = {24'h0, a[8:1], 16'h0000};
    end
`ifdef FT800_BYTE_SWAP_EN
    exp_rd = {mvec[15:8], mvec[7:0]};
`else
    exp_rd = {mvec[7:0], mvec[15:8]};
`endif

    addr    = a;
    write   = (kind == 1);
    command = (kind == 2);
    if (kind == 2) write = 1'($urandom);
    tb_oe   = 1'b1;
    tb_dout = wd;
    miso    = mvec[47];
    enable  = 1'b1;

    got = '0; rises = 0; last_rise = -100; cs_drop = -1;
    timing_ok = 1'b1; done = 1'b0;
    prev_sclk = 1'b0; prev_cs = 1'b0; prev_mosi = mosi;

    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 0) begin
        check({tag, "_cs_start"}, 64'(chip_select), 64'(1));
        tb_dout = 16'h0000;
        addr    = 21'($urandom);
        write   = 1'($urandom);
        command = 1'($urandom);
      end
      if (drop_early && cyc == 5) enable = 1'b0;
      if (!prev_sclk && spi_clk) begin
        got = {got[46:0], mosi};
        if (cyc != ((rises == 0) ? H : last_rise + 2 * H)) timing_ok = 1'b0;
        last_rise = cyc;
        rises++;
        if (rises < 48) miso = mvec[47 - rises];
      end
      if (cyc != 0 && mosi !== prev_mosi && !(prev_sclk && !spi_clk)) timing_ok = 1'b0;
      if (spi_clk && !chip_select) timing_ok = 1'b0;
      if (prev_cs && !chip_select) begin
        cs_drop = cyc;
        if (spi_clk) timing_ok = 1'b0;
      end
      if (complete) done = 1'b1;
      prev_sclk = spi_clk;
      prev_cs   = chip_select;
      prev_mosi = mosi;
    end

    check({tag, "_complete"}, 64'(complete), 64'(1));
    check({tag, "_rises"}, 64'(rises), 64'(len));
    check({tag, "_frame"}, 64'(got), 64'(exp_frame));
    check({tag, "_timing"}, 64'(timing_ok), 64'(1));
    check({tag, "_cs_drop"}, 64'(cs_drop - last_rise), 64'(H));

    if (!drop_early) begin
      if (kind == 0) tb_oe = 1'b0;
      for (int i = 0; i < 3; i++) begin
        check({tag, "_hold_cmpl"}, 64'(complete), 64'(1));
        check({tag, "_hold_cs"}, 64'({chip_select, spi_clk}), 64'(0));
        check({tag, "_hold_data"}, 64'(data), (kind == 0) ? 64'(exp_rd) : 64'(0));
        @(posedge clk); #1;
      end
      enable  = 1'b0;
      tb_oe   = 1'b1;
      tb_dout = 16'h0000;
      @(posedge clk); #1;
      check({tag, "_release_cmpl"}, 64'(complete), 64'(0));
      check({tag, "_release_data"}, 64'(data), 64'(0));
    end else begin
      @(posedge clk); #1;
      check({tag, "_early_cmpl"}, 64'(complete), 64'(0));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; addr = '0; write = 1'b0; command = 1'b0;
    miso = 1'b0; tb_oe = 1'b1; tb_dout = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs", 64'(chip_select), 64'(0));
    check("rst_sclk", 64'(spi_clk), 64'(0));
    check("rst_mosi", 64'(mosi), 64'(0));
    check("rst_cmpl", 64'(complete), 64'(0));
    check("rst_data", 64'(data), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    access(0, 21'h17d557, 16'h0000, 48'hAAAA_AAAA_AAAA, 1'b0, "rd_toggle");
    access(0, 21'($urandom), 16'h0000, {32'($urandom), 16'h3412}, 1'b0, "rd_1234");
    access(1, 21'h000100, 16'hBEEF, 48'($urandom), 1'b0, "wr_beef");
    access(2, 21'h000044, 16'h0000, 48'($urandom), 1'b0, "cmd_44");

    // Reset in the middle of a read frame.
    addr = 21'h0abcde; write = 1'b0; command = 1'b0; enable = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1; enable = 1'b0;
    @(posedge clk); #1;
    check("midrst_cs", 64'(chip_select), 64'(0));
    check("midrst_sclk", 64'(spi_clk), 64'(0));
    check("midrst_cmpl", 64'(complete), 64'(0));
    check("midrst_mosi", 64'(mosi), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_idle_cs", 64'(chip_select), 64'(0));
    access(0, 21'h1fffff, 16'h0000, {32'($urandom), 16'h5aa5}, 1'b0, "post_rst_rd");

    access(1, 21'($urandom), 16'($urandom), 48'($urandom), 1'b1, "wr_drop");
    access(0, 21'($urandom), 16'h0000, {32'($urandom), 16'($urandom)}, 1'b1, "rd_drop");

    for (int n = 0; n < 8; n++) begin
      access(int'($urandom_range(0, 2)), 21'($urandom), 16'($urandom),
             {16'($urandom), 32'($urandom)}, 1'b0, $sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
